// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the instruction store. Takes a program image as a
//   valid/ready byte stream (2-byte big-endian word count N, then 4*N bytes,
//   each word big-endian) and writes it one 32-bit word at a time at byte
//   addresses 0, 4, 8, ... The core is held off via cpu_hold while loading.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           one-cycle load request, honoured only while idle
//   in_data/in_valid/in_ready   byte stream handshake
//   mem_we/mem_addr/mem_data    one-cycle word write strobe, byte address, word
//   cpu_hold        high while a load is in progress (same as busy)
//   busy            load in progress
//   done            one-cycle pulse on successful completion
//   err             sticky: header count exceeded capacity; cleared by start/reset
//   words_loaded    words written in the current/last load
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = (2 ** ADDR_WIDTH) / 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-2:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        xfer;
  logic [7:0]  n_hi;
  logic [15:0] n_cnt;
  logic [15:0] n_full;
  logic [23:0] word_acc;
  logic [1:0]  byte_idx;
  logic        last_word;

  assign xfer     = in_valid && in_ready;
  assign n_full   = {n_hi, in_data};
  assign cpu_hold = busy;

  // Compare on the full 16-bit count so oversized headers cannot alias.
  assign last_word = (16'(words_loaded) + 16'd1) == n_cnt;

  // Next state and the purely state-decoded outputs.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = HDR_HI;
      end
      HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = HDR_LO;
      end
      HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (n_full == 16'd0)                   state_nx = DONE;
          else if (n_full > 16'(MAX_WORDS))      state_nx = ERROR;
          else                                   state_nx = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && (byte_idx == 2'd3)) state_nx = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        state_nx = last_word ? DONE : DATA;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      ERROR: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state and the registered outputs that must come up at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      byte_idx     <= 2'd0;
      mem_addr     <= '0;
      mem_data     <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            err          <= 1'b0;
            words_loaded <= '0;
            busy         <= 1'b1;
          end
        end
        HDR_LO: begin
          if (xfer) byte_idx <= 2'd0;
        end
        DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            // Output registers load on the 4th byte so the write cycle sees
            // a stable word while word_acc is free to collect the next one.
            if (byte_idx == 2'd3) begin
              mem_data <= {word_acc, in_data};
              mem_addr <= {words_loaded[ADDR_WIDTH-3:0], 2'b00};
            end
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 1'b1;
        end
        DONE: begin
          busy <= 1'b0;
        end
        ERROR: begin
          err  <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Header and word assembly registers; contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (xfer && (state == HDR_HI)) n_hi  <= in_data;
    if (xfer && (state == HDR_LO)) n_cnt <= n_full;
    if (xfer && (state == DATA))   word_acc <= {word_acc[15:0], in_data};
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized byte stream with a stream-parsing
// reference model and per-cycle output comparison.
module tb_imem_loader;

  localparam int MAXW = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [31:0] mem_data;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] words_loaded;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model state (what the outputs must be, derived from the stream).
  bit          busy_exp = 0;
  bit          err_exp  = 0;
  bit          err_pend = 0;
  int          wl_exp   = 0;
  int          n_exp    = 0;
  int          nb       = 0;
  int          wr_cyc   = -1;
  int          done_cyc = -1;
  int          end_cyc  = -1;
  int          wr_addr  = 0;
  int          last_addr = 0;
  logic [7:0]  nhi = 8'd0;
  logic [31:0] wacc = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] last_data = 32'd0;

  // Observations for literal end-of-load checks.
  logic [31:0] mem_img [0:255];
  int          load_writes = 0;
  int          load_dones  = 0;
  int          hold_cycles = 0;
  int          last_wr_addr = -1;

  logic [7:0]  img[$];
  logic [31:0] w5 [0:255];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40)
        $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic img_hdr(int n);
    img.delete();
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
  endtask

  task automatic img_word(logic [31:0] w);
    img.push_back(w[31:24]);
    img.push_back(w[23:16]);
    img.push_back(w[15:8]);
    img.push_back(w[7:0]);
  endtask

  always @(negedge clk) begin : mon
    bit          busy_now;
    bit          we_now;
    bit          rdy_now;
    int          exp_addr;
    logic [31:0] exp_data;
    cyc++;
    busy_now = busy_exp;
    we_now   = (cyc == wr_cyc);
    rdy_now  = busy_now && !we_now && (cyc != end_cyc);
    exp_addr = we_now ? wr_addr : last_addr;
    exp_data = we_now ? wr_data : last_data;

    chk("busy",         32'(busy),         32'(busy_now));
    chk("cpu_hold",     32'(cpu_hold),     32'(busy_now));
    chk("in_ready",     32'(in_ready),     32'(rdy_now));
    chk("mem_we",       32'(mem_we),       32'(we_now));
    chk("mem_addr",     32'(mem_addr),     32'(exp_addr));
    chk("mem_data",     mem_data,          exp_data);
    chk("done",         32'(done),         32'(cyc == done_cyc));
    chk("err",          32'(err),          32'(err_exp));
    chk("words_loaded", 32'(words_loaded), 32'(wl_exp));

    if (mem_we === 1'b1) begin
      mem_img[mem_addr[9:2]] = mem_data;
      load_writes++;
      last_wr_addr = int'(mem_addr);
    end
    if (busy === 1'b1) hold_cycles++;
    if (done === 1'b1) load_dones++;

    if (reset) begin
      busy_exp = 0; err_exp = 0; err_pend = 0; wl_exp = 0; nb = 0;
      wr_cyc = -1; done_cyc = -1; end_cyc = -1;
      last_addr = 0; last_data = 32'd0;
    end else begin
      if (we_now) begin
        last_addr = wr_addr;
        last_data = wr_data;
        wl_exp++;
        if (wl_exp == n_exp) begin
          done_cyc = cyc + 1;
          end_cyc  = cyc + 1;
        end
      end
      if (cyc == end_cyc) begin
        busy_exp = 0;
        if (err_pend) err_exp = 1;
        err_pend = 0;
      end
      if (!busy_now && start) begin
        busy_exp = 1; err_exp = 0; wl_exp = 0; nb = 0;
        load_writes = 0; load_dones = 0; hold_cycles = 0; last_wr_addr = -1;
      end
      if (rdy_now && in_valid) begin
        nb++;
        if (nb == 1) begin
          nhi = in_data;
        end else if (nb == 2) begin
          n_exp = int'({nhi, in_data});
          if (n_exp == 0) begin
            done_cyc = cyc + 1;
            end_cyc  = cyc + 1;
          end else if (n_exp > MAXW) begin
            end_cyc  = cyc + 1;
            err_pend = 1;
          end
        end else begin
          wacc = {wacc[23:0], in_data};
          if (((nb - 2) % 4) == 0) begin
            wr_cyc  = cyc + 1;
            wr_addr = ((nb - 2) / 4 - 1) * 4;
            wr_data = wacc;
          end
        end
      end
    end
  end

  task automatic run_load(int gap_pct, int abort_words, bit start_noise);
    int ptr = 0;
    int budget = 0;
    bit x;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (busy === 1'b1) begin
      budget++;
      if (budget > 6000) begin
        ncmp++; nerr++;
        $display("FAIL load_timeout: busy still high after %0d cycles, want low", budget);
        break;
      end
      if (abort_words > 0 && load_writes >= abort_words) begin
        reset = 1'b1; in_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        break;
      end
      in_valid = (ptr < img.size()) && ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? img[ptr] : 8'($urandom);
      start    = start_noise && ($urandom_range(19) == 0);
      @(negedge clk);
      x = in_valid && in_ready;
      @(posedge clk); #1;
      if (x) ptr++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", mem_data,      32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_words",    32'(words_loaded), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single word.
    img_hdr(1); img_word(32'hDEADBEEF);
    run_load(0, 0, 0);
    #1;
    chk("t1_writes", 32'(load_writes), 32'd1);
    chk("t1_word0",  mem_img[0], 32'hDEADBEEF);
    chk("t1_words",  32'(words_loaded), 32'd1);
    chk("t1_hold",   32'(cpu_hold), 32'd0);
    chk("t1_dones",  32'(load_dones), 32'd1);
    chk("t1_window", 32'(hold_cycles), 32'd8);

    // Three words with stalls and stray starts.
    img_hdr(3); img_word(32'h11111111); img_word(32'h22222222); img_word(32'h33333333);
    run_load(40, 0, 1);
    #1;
    chk("t2_writes", 32'(load_writes), 32'd3);
    chk("t2_word0",  mem_img[0], 32'h11111111);
    chk("t2_word1",  mem_img[1], 32'h22222222);
    chk("t2_word2",  mem_img[2], 32'h33333333);
    chk("t2_lastad", 32'(last_wr_addr), 32'd8);

    // Empty image.
    img_hdr(0);
    run_load(0, 0, 0);
    #1;
    chk("t3_writes", 32'(load_writes), 32'd0);
    chk("t3_dones",  32'(load_dones), 32'd1);
    chk("t3_window", 32'(hold_cycles), 32'd3);

    // Oversized header; trailing bytes must stay unconsumed.
    img_hdr(257); img_word(32'hCAFEF00D); img_word(32'h01234567);
    run_load(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_err",    32'(err), 32'd1);
    chk("t4_writes", 32'(load_writes), 32'd0);
    chk("t4_dones",  32'(load_dones), 32'd0);
    chk("t4_window", 32'(hold_cycles), 32'd3);
    chk("t4_ready",  32'(in_ready), 32'd0);

    // Full capacity, continuous stream.
    img_hdr(256);
    for (int i = 0; i < 256; i++) begin
      w5[i] = $urandom;
      img_word(w5[i]);
    end
    run_load(0, 0, 0);
    #1;
    chk("t5_err",    32'(err), 32'd0);
    chk("t5_writes", 32'(load_writes), 32'd256);
    chk("t5_lastad", 32'(last_wr_addr), 32'h3FC);
    chk("t5_words",  32'(words_loaded), 32'd256);
    chk("t5_dones",  32'(load_dones), 32'd1);
    chk("t5_window", 32'(hold_cycles), 32'd1283);
    chk("t5_first",  mem_img[0], w5[0]);
    chk("t5_last",   mem_img[255], w5[255]);

    // Reset after two of three words.
    img_hdr(3); img_word(32'hAAAA0001); img_word(32'hAAAA0002); img_word(32'hAAAA0003);
    run_load(0, 2, 0);
    #1;
    chk("t6_writes", 32'(load_writes), 32'd2);
    chk("t6_word1",  mem_img[1], 32'hAAAA0002);
    chk("t6_word2",  mem_img[2], w5[2]);
    chk("t6_busy",   32'(busy), 32'd0);
    chk("t6_addr",   32'(mem_addr), 32'd0);
    chk("t6_data",   mem_data, 32'd0);
    chk("t6_words",  32'(words_loaded), 32'd0);
    repeat (3) @(posedge clk);

    // Clean reload after the abort.
    img_hdr(3); img_word(32'h5A5A0001); img_word(32'h5A5A0002); img_word(32'h5A5A0003);
    run_load(20, 0, 1);
    #1;
    chk("t7_writes", 32'(load_writes), 32'd3);
    chk("t7_word2",  mem_img[2], 32'h5A5A0003);
    chk("t7_dones",  32'(load_dones), 32'd1);

    // Random images.
    for (int t = 0; t < 8; t++) begin
      int n;
      n = (t == 3) ? 0 : int'($urandom_range(12, 1));
      img_hdr(n);
      for (int i = 0; i < n; i++) img_word($urandom);
      run_load(int'($urandom_range(60, 0)), 0, 1);
      #1;
      chk("rnd_writes", 32'(load_writes), 32'(n));
      chk("rnd_dones",  32'(load_dones), 32'd1);
      chk("rnd_words",  32'(words_loaded), 32'(n));
      repeat (int'($urandom_range(3, 0))) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
